// File: rtl/surf_wb_arbiter_if.sv
// Bus bundle for surf_wb_arbiter: two WISHBONE masters (bm = serial master,
// tc = TURF command master) sharing one WISHBONE slave.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding masters and the shared slave.
interface surf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    // serial master
    logic                  bm_cyc_i;
    logic                  bm_stb_i;
    logic                  bm_we_i;
    logic [ADDR_WIDTH-1:0] bm_adr_i;
    logic [DATA_WIDTH-1:0] bm_dat_i;
    logic [SEL_WIDTH-1:0]  bm_sel_i;
    logic                  bm_ack_o;
    logic                  bm_err_o;
    logic [DATA_WIDTH-1:0] bm_dat_o;

    // TURF command master
    logic                  tc_cyc_i;
    logic                  tc_stb_i;
    logic                  tc_we_i;
    logic [ADDR_WIDTH-1:0] tc_adr_i;
    logic [DATA_WIDTH-1:0] tc_dat_i;
    logic [SEL_WIDTH-1:0]  tc_sel_i;
    logic                  tc_ack_o;
    logic                  tc_err_o;
    logic [DATA_WIDTH-1:0] tc_dat_o;

    // shared slave
    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic                  s_we_o;
    logic [ADDR_WIDTH-1:0] s_adr_o;
    logic [DATA_WIDTH-1:0] s_dat_o;
    logic [SEL_WIDTH-1:0]  s_sel_o;
    logic                  s_ack_i;
    logic                  s_err_i;
    logic [DATA_WIDTH-1:0] s_dat_i;

    modport slave (
        input  bm_cyc_i, bm_stb_i, bm_we_i, bm_adr_i, bm_dat_i, bm_sel_i,
        output bm_ack_o, bm_err_o, bm_dat_o,
        input  tc_cyc_i, tc_stb_i, tc_we_i, tc_adr_i, tc_dat_i, tc_sel_i,
        output tc_ack_o, tc_err_o, tc_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_err_i, s_dat_i
    );

    modport master (
        output bm_cyc_i, bm_stb_i, bm_we_i, bm_adr_i, bm_dat_i, bm_sel_i,
        input  bm_ack_o, bm_err_o, bm_dat_o,
        output tc_cyc_i, tc_stb_i, tc_we_i, tc_adr_i, tc_dat_i, tc_sel_i,
        input  tc_ack_o, tc_err_o, tc_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_err_i, s_dat_i
    );
endinterface

// File: rtl/surf_wb_arbiter.sv
// Two-master WISHBONE arbiter with round-robin tie breaking, grant held for
// the owner's whole cycle, and a watchdog that forces a one-cycle error when
// the slave fails to respond within TIMEOUT strobed cycles.
module surf_wb_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    surf_wb_arbiter_if.slave     bus,
    output logic [1:0]           grant_o,
    output logic                 timeout_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        GNT_BM,
        GNT_TC,
        TOERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_tc;
    logic        last_tc_nxt;
    logic        armed;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic        own_cyc;
    logic        own_stb;

    logic                  req_cyc;
    logic                  req_stb;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_adr;
    logic [DATA_WIDTH-1:0] req_dat;
    logic [SEL_WIDTH-1:0]  req_sel;

    // State, round-robin memory, watchdog count, and a one-cycle hold-off after reset release
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            last_tc  <= 1'b1;
            armed    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_tc  <= last_tc_nxt;
            armed    <= 1'b1;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Cycle and strobe of whichever master currently owns the slave
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state)
            GNT_BM: begin
                own_cyc = bus.bm_cyc_i;
                own_stb = bus.bm_stb_i;
            end
            GNT_TC: begin
                own_cyc = bus.tc_cyc_i;
                own_stb = bus.tc_stb_i;
            end
            default: ;
        endcase
    end

    // Arbitration, release, and watchdog transitions
    always_comb begin
        state_nxt    = state;
        last_tc_nxt  = last_tc;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (armed) begin
                    if (bus.bm_cyc_i && bus.tc_cyc_i) begin
                        state_nxt   = last_tc ? GNT_BM : GNT_TC;
                        last_tc_nxt = !last_tc;
                    end else if (bus.bm_cyc_i) begin
                        state_nxt   = GNT_BM;
                        last_tc_nxt = 1'b0;
                    end else if (bus.tc_cyc_i) begin
                        state_nxt   = GNT_TC;
                        last_tc_nxt = 1'b1;
                    end
                end
            end
            GNT_BM, GNT_TC: begin
                if (!own_cyc) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (bus.s_ack_i || bus.s_err_i) begin
                    wait_cnt_nxt = '0;
                end else if (own_stb) begin
                    if (wait_cnt == TIMEOUT_LAST) begin
                        state_nxt    = TOERR;
                        wait_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 16'd1;
                    end
                end
            end
            TOERR: begin
                wait_cnt_nxt = '0;
                if (last_tc) begin
                    state_nxt = bus.tc_cyc_i ? GNT_TC : IDLE;
                end else begin
                    state_nxt = bus.bm_cyc_i ? GNT_BM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route the owner's request to the slave; everything is quiet otherwise
    always_comb begin
        req_cyc = 1'b0;
        req_stb = 1'b0;
        req_we  = 1'b0;
        req_adr = '0;
        req_dat = '0;
        req_sel = '0;
        case (state)
            GNT_BM: begin
                req_cyc = bus.bm_cyc_i;
                req_stb = bus.bm_stb_i;
                req_we  = bus.bm_we_i;
                req_adr = bus.bm_adr_i;
                req_dat = bus.bm_dat_i;
                req_sel = bus.bm_sel_i;
            end
            GNT_TC: begin
                req_cyc = bus.tc_cyc_i;
                req_stb = bus.tc_stb_i;
                req_we  = bus.tc_we_i;
                req_adr = bus.tc_adr_i;
                req_dat = bus.tc_dat_i;
                req_sel = bus.tc_sel_i;
            end
            default: ;
        endcase
    end

    assign bus.s_cyc_o = req_cyc;
    assign bus.s_stb_o = req_stb;
    assign bus.s_we_o  = req_we;
    assign bus.s_adr_o = req_adr;
    assign bus.s_dat_o = req_dat;
    assign bus.s_sel_o = req_sel;

    // Return slave responses to the owner only; acks after the owner drops cyc are discarded
    always_comb begin
        bus.bm_ack_o = 1'b0;
        bus.bm_err_o = 1'b0;
        bus.bm_dat_o = '0;
        bus.tc_ack_o = 1'b0;
        bus.tc_err_o = 1'b0;
        bus.tc_dat_o = '0;
        grant_o      = 2'b00;
        timeout_o    = 1'b0;
        case (state)
            GNT_BM: begin
                bus.bm_ack_o = bus.s_ack_i && bus.bm_cyc_i;
                bus.bm_err_o = bus.s_err_i && bus.bm_cyc_i;
                bus.bm_dat_o = bus.s_dat_i;
                grant_o      = 2'b01;
            end
            GNT_TC: begin
                bus.tc_ack_o = bus.s_ack_i && bus.tc_cyc_i;
                bus.tc_err_o = bus.s_err_i && bus.tc_cyc_i;
                bus.tc_dat_o = bus.s_dat_i;
                grant_o      = 2'b10;
            end
            TOERR: begin
                timeout_o = 1'b1;
                if (last_tc) begin
                    bus.tc_err_o = 1'b1;
                    grant_o      = 2'b10;
                end else begin
                    bus.bm_err_o = 1'b1;
                    grant_o      = 2'b01;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_surf_wb_arbiter.sv
// Self-checking bench for surf_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_surf_wb_arbiter;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int TO = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    logic       timeout;

    int vectors;
    int miscompares;

    // model: owner 0=none 1=bm 2=tc, plus watchdog and round-robin memory
    int mOwner, mWait, mLast;
    bit mToerr, mArmed;
    int nOwner, nWait, nLast;
    bit nToerr, nArmed;

    surf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    surf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus.slave),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic resetModel();
        mOwner = 0;
        mWait  = 0;
        mLast  = 2;
        mToerr = 1'b0;
        mArmed = 1'b0;
    endtask

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [1:0]  eGrant;
        logic        eTo, eCyc, eStb;
        logic [58:0] eReq;
        logic [33:0] eBm, eTc;
        eGrant = 2'b00;
        eTo    = 1'b0;
        eCyc   = 1'b0;
        eStb   = 1'b0;
        eReq   = '0;
        eBm    = '0;
        eTc    = '0;
        if (mToerr) begin
            eTo = 1'b1;
            if (mLast == 1) begin
                eGrant = 2'b01;
                eBm    = {1'b0, 1'b1, 32'h0};
            end else begin
                eGrant = 2'b10;
                eTc    = {1'b0, 1'b1, 32'h0};
            end
        end else if (mOwner == 1) begin
            eGrant = 2'b01;
            eCyc   = bus.bm_cyc_i;
            eStb   = bus.bm_stb_i;
            eReq   = {bus.bm_we_i, bus.bm_adr_i, bus.bm_dat_i, bus.bm_sel_i};
            eBm    = {bus.s_ack_i & bus.bm_cyc_i, bus.s_err_i & bus.bm_cyc_i, bus.s_dat_i};
        end else if (mOwner == 2) begin
            eGrant = 2'b10;
            eCyc   = bus.tc_cyc_i;
            eStb   = bus.tc_stb_i;
            eReq   = {bus.tc_we_i, bus.tc_adr_i, bus.tc_dat_i, bus.tc_sel_i};
            eTc    = {bus.s_ack_i & bus.tc_cyc_i, bus.s_err_i & bus.tc_cyc_i, bus.s_dat_i};
        end
        compare("grant", 64'(grant), 64'(eGrant));
        compare("timeout", 64'(timeout), 64'(eTo));
        compare("s_cyc", 64'(bus.s_cyc_o), 64'(eCyc));
        compare("s_stb", 64'(bus.s_stb_o), 64'(eStb));
        compare("s_req", 64'({bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o}), 64'(eReq));
        compare("bm_resp", 64'({bus.bm_ack_o, bus.bm_err_o, bus.bm_dat_o}), 64'(eBm));
        compare("tc_resp", 64'({bus.tc_ack_o, bus.tc_err_o, bus.tc_dat_o}), 64'(eTc));
    endtask

    // what the arbiter should do at the coming edge, from the current inputs
    task automatic predictNext();
        bit cyc [1:2];
        bit stb [1:2];
        cyc[1] = bus.bm_cyc_i;
        cyc[2] = bus.tc_cyc_i;
        stb[1] = bus.bm_stb_i;
        stb[2] = bus.tc_stb_i;
        nOwner = mOwner;
        nWait  = mWait;
        nLast  = mLast;
        nToerr = 1'b0;
        nArmed = 1'b1;
        if (mToerr) begin
            nOwner = cyc[mLast] ? mLast : 0;
            nWait  = 0;
        end else if (mOwner == 0) begin
            nWait = 0;
            if (mArmed) begin
                if (cyc[1] && cyc[2]) nOwner = 3 - mLast;
                else if (cyc[1])      nOwner = 1;
                else if (cyc[2])      nOwner = 2;
                if (nOwner != 0) nLast = nOwner;
            end
        end else if (!cyc[mOwner]) begin
            nOwner = 0;
            nWait  = 0;
        end else if (bus.s_ack_i || bus.s_err_i) begin
            nWait = 0;
        end else if (stb[mOwner]) begin
            if (mWait + 1 == TO) begin
                nToerr = 1'b1;
                nOwner = 0;
                nWait  = 0;
            end else begin
                nWait = mWait + 1;
            end
        end
    endtask

    task automatic clockCycle();
        #1;
        checkOutput();
        predictNext();
        @(posedge clk);
        if (rst_n) begin
            mOwner = nOwner;
            mWait  = nWait;
            mLast  = nLast;
            mToerr = nToerr;
            mArmed = nArmed;
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit bc, input bit bs, input bit bw,
                                 input bit tcyc, input bit ts, input bit tw,
                                 input bit sa, input bit se, input logic [31:0] sd);
        bus.bm_cyc_i = bc;
        bus.bm_stb_i = bs;
        bus.bm_we_i  = bw;
        bus.bm_adr_i = AW'($urandom);
        bus.bm_dat_i = $urandom;
        bus.bm_sel_i = 4'($urandom);
        bus.tc_cyc_i = tcyc;
        bus.tc_stb_i = ts;
        bus.tc_we_i  = tw;
        bus.tc_adr_i = AW'($urandom);
        bus.tc_dat_i = $urandom;
        bus.tc_sel_i = 4'($urandom);
        bus.s_ack_i  = sa;
        bus.s_err_i  = se;
        bus.s_dat_i  = sd;
        clockCycle();
    endtask

    initial begin
        bit bc, tcyc;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        resetModel();
        @(negedge clk);

        // reset holds everything quiet even with requests and responses present
        repeat (3) applyStimulus(1, 1, 1, 1, 1, 1, 1, 1, $urandom);

        // single bm read acked on its third strobed cycle
        rst_n = 1'b1;
        repeat (4) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, $urandom);
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, $urandom);

        // simultaneous requests straight after reset: bm first, then tc, then bm again
        rst_n = 1'b0;
        resetModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1, 1, 0, 1, 1, 1, 0, 0, $urandom);
        applyStimulus(1, 1, 0, 1, 1, 1, 1, 0, $urandom);
        repeat (3) applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, $urandom);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 0, $urandom);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
        repeat (3) applyStimulus(1, 1, 0, 1, 1, 1, 0, 0, $urandom);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, $urandom);

        // tc burst of four acked strobes while bm waits
        applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, $urandom);
        repeat (4) applyStimulus(1, 1, 0, 1, 1, 1, 1, 0, $urandom);
        repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, $urandom);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, $urandom);

        // tc write the slave never answers: watchdog fires, then restarts
        repeat (22) applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, $urandom);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, $urandom);

        // asynchronous reset in the middle of a bm access
        repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, $urandom);
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput();
        repeat (2) applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, $urandom);
        rst_n = 1'b1;
        repeat (4) applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, $urandom);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, $urandom);

        // random traffic with alternating responsive and silent slave phases
        bc   = 1'b0;
        tcyc = 1'b0;
        for (int i = 0; i < 800; i++) begin
            bit slow, sa, se;
            slow = (i % 80) < 30;
            if (slow) begin
                if ($urandom_range(15) == 0) bc   = !bc;
                if ($urandom_range(15) == 0) tcyc = !tcyc;
                sa = 1'b0;
                se = 1'b0;
            end else begin
                if ($urandom_range(4) == 0) bc   = !bc;
                if ($urandom_range(4) == 0) tcyc = !tcyc;
                sa = $urandom_range(9) < 3;
                se = $urandom_range(19) == 0;
            end
            applyStimulus(bc, bc & ($urandom_range(3) != 0), 1'($urandom),
                          tcyc, tcyc & ($urandom_range(3) != 0), 1'($urandom),
                          sa, se, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
